div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//   Multi-cycle iterative divider sequencer for DIV/DIVU in the execute stage.
//   Latches operands, runs a restoring shift-subtract loop one bit per cycle, and holds
//   stall_div high so the hazard logic freezes IF/ID/EX while the loop runs.
//   Delivers quotient/remainder with a one-cycle result_valid, which drives the LO/HI write.
// PARAMETERS
//   WIDTH     32   operand width; the iteration count equals WIDTH
//   CNT_W     6    counter width; must be >= clog2(WIDTH+1)
// PORTS
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous, active-high reset
//   startE        in   1      DIV/DIVU decoded in EX and the EX stage is valid
//   signedE       in   1      1=DIV (two's complement), 0=DIVU
//   srcaE         in   WIDTH  dividend (rs)
//   srcbE         in   WIDTH  divisor (rt)
//   annulE        in   1      flushE or exception: abort any operation in flight
//   stall_div     out  1      freeze IF/ID/EX this cycle
//   busy          out  1      registered: state != IDLE
//   result_valid  out  1      one-cycle strobe: quotient/remainder are valid
//   quotient      out  WIDTH  written to LO when result_valid=1
//   remainder     out  WIDTH  written to HI when result_valid=1
// BEHAVIOUR
//   Reset (async): state=IDLE, counter=0, all internal registers=0.
//     Also on reset: busy=0, result_valid=0, quotient=0, remainder=0, stall_div=0.
//   States: IDLE, PREP, RUN, DONE.
//   IDLE
//     stall_div = startE & ~annulE (combinational).
//     startE & ~annulE & (srcbE!=0): latch operands and signedE -> PREP.
//     startE & ~annulE & (srcbE==0): quotient={WIDTH{1}}, remainder=srcaE -> DONE.
//     Division by zero ignores signedE and skips the loop.
//   PREP
//     Convert operands to magnitudes when signed; record qneg=sa^sb and rneg=sa.
//     Clear the partial remainder; counter=WIDTH -> RUN. stall_div=1.
//   RUN
//     Each cycle: {rem,dvd} <<= 1; if rem >= divisor then rem -= divisor and dvd[0]=1.
//     Counter decrements. When the counter reaches 1 on this cycle -> DONE. stall_div=1.
//     Exactly WIDTH RUN cycles.
//   DONE
//     Register sign-corrected results: quotient negated if qneg, remainder negated if rneg.
//     result_valid=1 for this single cycle; stall_div=0, so the DIV leaves EX at this edge.
//     Always -> IDLE. startE is ignored in DONE.
//     A new divide may start in the next IDLE cycle.
//   Latency: start accepted in cycle 0 (IDLE) gives result_valid in cycle WIDTH+2.
//     stall_div is high in cycles 0..WIDTH+1, i.e. WIDTH+2 stall cycles (34 at WIDTH=32).
//   quotient/remainder hold their last value until the next DONE.
//   annulE in any state, including the start cycle and DONE:
//     next state is IDLE; result_valid is forced 0 that cycle; stall_div=0 that cycle.
//     The held quotient/remainder are not updated.
//   Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0.
//     This is plain truncation; no trap is raised.
//   Signs follow MIPS truncation toward zero: the remainder takes the sign of the dividend.
//   stall_div does not depend on stall inputs; the divider owns EX while busy.
//   Mid-operation reset: immediate return to IDLE with all outputs 0.
// TESTING
//   DIVU 100/7: startE=1 one cycle, then held per stall
//     -> result_valid in cycle 34; q=14, r=2; stall_div high in cycles 0..33.
//   DIV -7/2 (0xFFFFFFF9, 2)
//     -> q=0xFFFFFFFD, r=0xFFFFFFFF.
//   DIV 7/-2
//     -> q=0xFFFFFFFD, r=1.
//   DIV 0x80000000/0xFFFFFFFF
//     -> q=0x80000000, r=0; no hang or X values.
//   DIVU 5/0
//     -> result_valid in cycle 1; q=0xFFFFFFFF, r=5; stall_div high in cycle 0 only.
//   Abort and restart
//     Stimulus: start 100/7, assert annulE in RUN cycle 10, then start 9/3 on the next cycle.
//     Required: no result_valid for the first divide; the second gives q=3, r=0 after 34 cycles.
//     Required: previous q/r held unchanged until that point.
//   Async rst asserted mid-RUN
//     -> busy, stall_div and result_valid go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/div_seq_if.sv
// Divider handshake bundle: EX-stage start/operands/annul in; stall, busy and LO/HI results out.
// The master drives the request side, the divider (slave) drives results and stall.
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic             signedE;
    logic             annulE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             stall_div;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output startE, signedE, annulE, srcaE, srcbE,
        input  stall_div, busy, result_valid, quotient, remainder
    );

    modport slave (
        input  startE, signedE, annulE, srcaE, srcbE,
        output stall_div, busy, result_valid, quotient, remainder
    );
endinterface

// File: rtl/div_seq.sv
// Restoring shift-subtract DIV/DIVU, one bit per cycle; result_valid WIDTH+2 cycles after start.
// No backpressure: stall_div freezes IF/ID/EX while busy; annulE aborts in any state.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst,
    div_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd, dsr, rem;
    logic [WIDTH-1:0] qRes, rRes, qHeld, rHeld;
    logic             sgn, qneg, rneg;

    logic [WIDTH:0]   remSh, diff;
    logic [WIDTH-1:0] remNext, dvdNext, qFix, rFix;
    logic             signA, signB, stallRaw;

    always_comb begin
        remSh = {rem, dvd[WIDTH-1]};
        diff  = remSh - {1'b0, dsr};
        // diff MSB is the borrow: set only when the shifted remainder is below the divisor
        if (!diff[WIDTH]) begin
            remNext = diff[WIDTH-1:0];
            dvdNext = {dvd[WIDTH-2:0], 1'b1};
        end else begin
            remNext = remSh[WIDTH-1:0];
            dvdNext = {dvd[WIDTH-2:0], 1'b0};
        end
        qFix  = qneg ? -dvdNext : dvdNext;
        rFix  = rneg ? -remNext : remNext;
        signA = sgn & dvd[WIDTH-1];
        signB = sgn & dsr[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            sgn   <= 1'b0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            qRes  <= '0;
            rRes  <= '0;
            qHeld <= '0;
            rHeld <= '0;
        end else if (bus.annulE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.startE) begin
                        if (bus.srcbE == '0) begin
                            qRes  <= '1;
                            rRes  <= bus.srcaE;
                            state <= DONE;
                        end else begin
                            dvd   <= bus.srcaE;
                            dsr   <= bus.srcbE;
                            sgn   <= bus.signedE;
                            state <= PREP;
                        end
                    end
                end
                PREP: begin
                    // Magnitudes only; -0x80000000 stays 0x80000000, which is the right unsigned magnitude
                    dvd   <= signA ? -dvd : dvd;
                    dsr   <= signB ? -dsr : dsr;
                    qneg  <= signA ^ signB;
                    rneg  <= signA;
                    rem   <= '0;
                    cnt   <= CNT_W'(WIDTH);
                    state <= RUN;
                end
                RUN: begin
                    rem <= remNext;
                    dvd <= dvdNext;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        qRes  <= qFix;
                        rRes  <= rFix;
                        state <= DONE;
                    end
                end
                default: begin
                    qHeld <= qRes;
                    rHeld <= rRes;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stallRaw = 1'b0;
        case (state)
            IDLE:      stallRaw = bus.startE;
            PREP, RUN: stallRaw = 1'b1;
            default:   stallRaw = 1'b0;
        endcase
    end

    // The new result is shown during DONE itself and only committed to the hold registers when not annulled
    assign bus.stall_div    = stallRaw & ~bus.annulE & ~rst;
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == DONE) & ~bus.annulE;
    assign bus.quotient     = bus.result_valid ? qRes : qHeld;
    assign bus.remainder    = bus.result_valid ? rRes : rHeld;
endmodule

// File: tb/tb_div_seq.sv
// Directed plus randomized checks of div_seq: cycle-by-cycle stall/valid/busy, held results,
// annul in start/RUN/DONE, async reset mid-RUN; results matched against a scoreboard queue.
module tb_div_seq;
    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    res_t sb[$];
    logic [31:0] lastQ, lastR;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        res_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (sgn) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Scoreboard consumer: every result_valid pops one expected result
    always @(negedge clk) begin
        res_t e;
        if (!rst && bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_quotient", bus.quotient, e.q);
                check("sb_remainder", bus.remainder, e.r);
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the posedge that ends the operation.
    task automatic runDiv(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                          input int annulAt);
        int lat;
        lat = (b == 32'd0) ? 1 : 34;
        if (annulAt < 0) sb.push_back('{q: eq, r: er});
        bus.startE  = 1'b1;
        bus.signedE = sgn;
        bus.srcaE   = a;
        bus.srcbE   = b;
        for (int i = 0; i <= lat; i++) begin
            if (i == annulAt) bus.annulE = 1'b1;
            @(negedge clk);
            if (i == annulAt) begin
                check({name, "/annul_stall"}, 32'(bus.stall_div), 32'd0);
                check({name, "/annul_valid"}, 32'(bus.result_valid), 32'd0);
                check({name, "/annul_busy"}, 32'(bus.busy), 32'(i > 0));
                check({name, "/annul_q_held"}, bus.quotient, lastQ);
                check({name, "/annul_r_held"}, bus.remainder, lastR);
                @(posedge clk);
                #1;
                bus.annulE = 1'b0;
                bus.startE = 1'b0;
                return;
            end
            check({name, "/stall"}, 32'(bus.stall_div), 32'(i < lat));
            check({name, "/valid"}, 32'(bus.result_valid), 32'(i == lat));
            check({name, "/busy"}, 32'(bus.busy), 32'(i > 0));
            check({name, "/quotient"}, bus.quotient, (i == lat) ? eq : lastQ);
            check({name, "/remainder"}, bus.remainder, (i == lat) ? er : lastR);
            @(posedge clk);
            #1;
            bus.startE = 1'b0;
        end
        lastQ = eq;
        lastR = er;
    endtask

    initial begin
        res_t e;
        logic [31:0] a, b;
        logic sgn;
        checks = 0;
        errors = 0;
        lastQ = '0;
        lastR = '0;
        rst = 1'b1;
        bus.startE  = 1'b0;
        bus.signedE = 1'b0;
        bus.annulE  = 1'b0;
        bus.srcaE   = '0;
        bus.srcbE   = '0;
        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_stall", 32'(bus.stall_div), 32'd0);
        check("reset_valid", 32'(bus.result_valid), 32'd0);
        check("reset_quotient", bus.quotient, 32'd0);
        check("reset_remainder", bus.remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, -1);
        runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
        runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, -1);
        runDiv("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, -1);
        runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, -1);
        runDiv("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7, -1);

        // Abort in RUN, then restart on the very next cycle
        runDiv("abort_run", 1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 12);
        runDiv("restart_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, -1);
        runDiv("abort_start", 1'b0, 32'd50, 32'd5, 32'd0, 32'd0, 0);
        runDiv("abort_done", 1'b1, 32'd77, 32'd5, 32'd0, 32'd0, 34);
        runDiv("abort_done_dz", 1'b0, 32'd11, 32'd0, 32'd0, 32'd0, 1);
        runDiv("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, -1);

        // Async reset in the middle of RUN
        bus.startE  = 1'b1;
        bus.signedE = 1'b0;
        bus.srcaE   = 32'd100;
        bus.srcbE   = 32'd7;
        @(posedge clk);
        #1;
        bus.startE = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_stall", 32'(bus.stall_div), 32'd0);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        lastQ = '0;
        lastR = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) begin
            a   = $urandom;
            sgn = 1'($urandom_range(0, 1));
            if (k == 3)          b = 32'd0;
            else if (k % 2 == 0) b = $urandom_range(1, 255);
            else                 b = $urandom;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            e = model(sgn, a, b);
            runDiv($sformatf("rand%0d", k), sgn, a, b, e.q, e.r, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
